red_pitaya_pid_block_shg: RTL and testbench
===========================================

Name: red_pitaya_pid_block_shg

Overview:
- Parametrised sample-and-hold PID controller; the next generation of the fixed-threshold S&H PID.
- Error is gated by a threshold on a trigger input. A programmable settle interval follows each hold. Trigger polarity is selectable. Output during hold is selectable.
- One instance per PID channel inside the PID matrix. Settings come from the PID register bank.

Parameters:
- DW, 14, data width of dat_i, dat_o, trig_i, setpoint, gains and threshold (signed two's complement).
- PSR, 12, right shift applied to the proportional product.
- ISR, 18, right shift applied to the integrator register.
- DSR, 10, right shift applied to the derivative product.
- CW, 8, settle counter width.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- dat_i  in  DW  process input (signed)
- trig_i  in  DW  sample/hold trigger signal (signed)
- dat_o  out  DW  controller output (signed, saturated)
- state_o  out  2  FSM state: 00 TRACK, 01 HOLD, 10 SETTLE
- set_sp_i  in  DW  set point
- set_kp_i  in  DW  Kp
- set_ki_i  in  DW  Ki
- set_kd_i  in  DW  Kd
- set_thr_i  in  DW  trigger threshold (signed)
- set_settle_i  in  CW  settle length; SETTLE lasts set_settle_i+1 cycles
- set_mode_i  in  2  bit0 trigger polarity; bit1 hold-output mode
- int_rst_i  in  1  integrator reset

Behaviour:
- Reset (rstn_i=0, asynchronous, any time including mid-hold or mid-settle):
  - all pipeline registers, integrator and settle counter clear to 0;
  - FSM goes to TRACK; dat_o=0; state_o=00.
- Trigger active (combinational):
  - mode[0]=0: $signed(trig_i) >= $signed(set_thr_i);
  - mode[0]=1: $signed(trig_i) <= $signed(set_thr_i).
- FSM, registered, evaluated every clock:
  - TRACK: error <= sp - dat_i (DW+1 bits, signed). Trigger active -> HOLD.
  - HOLD: error <= 0; counter <= 0. Trigger inactive -> SETTLE.
  - SETTLE: error <= 0.
    - Trigger active -> HOLD, counter cleared.
    - Else if counter == set_settle_i -> TRACK.
    - Else counter <= counter+1.
    - set_settle_i=0 gives a 1-cycle SETTLE.
  - Counter never wraps. set_settle_i changes take effect on the next comparison.
- Error register update: error is updated in the same cycle as the state register, using the pre-transition state. The first HOLD-state cycle therefore still carries the last tracked error; error reads 0 from the second HOLD cycle.
- P path:
  - kp_reg <= (error * Kp)[2DW:PSR], with a 2DW+1 bit signed product;
  - one register stage.
- I path:
  - ki_mult <= error * Ki;
  - int_sum = ki_mult + int_reg, 33 bits;
  - int_reg is 32 bits, updated each cycle, with this priority:
    1. int_rst_i -> 0;
    2. positive overflow (int_sum[32:31]=01) -> 0x7FFFFFFF;
    3. negative overflow (10) -> 0x80000000;
    4. otherwise int_sum[31:0].
  - int_shr = int_reg[31:ISR].
  - In HOLD/SETTLE, ki_mult becomes 0 one cycle after error does, so the integrator holds. The in-flight product from the last TRACK error is still accumulated (not discarded).
  - int_rst_i is honoured in every FSM state.
- D path:
  - kd_reg <= (error*Kd)[2DW:DSR];
  - kd_reg_r <= kd_reg;
  - kd_reg_s <= kd_reg - kd_reg_r, sign-extended one bit.
- Sum and saturate:
  - pid_sum = kp_reg + int_shr + kd_reg_s, sign-extended to 33 bits;
  - pid_out saturates to [-2^(DW-1), 2^(DW-1)-1]; DW=14 gives 0x1FFF / 0x2000.
- Output selection: dat_o = pid_out, except when mode[1]=1. In that case dat_o is a registered copy that freezes while the delayed state (state aligned to output latency, 3-cycle pipe) is HOLD or SETTLE, and is reloaded from pid_out otherwise.
  - mode[1]=0: legacy behaviour. P goes to 0, D gives a transient, I is held.
- Latency, dat_i to dat_o via P path:
  - 3 cycles in TRACK (error, kp_reg, pid_out);
  - +1 cycle when mode[1]=1 (output register).
- Simultaneous events:
  - trigger entry and int_rst_i in the same cycle: both take effect;
  - reset dominates everything.

Test Plan:
- Reset mid-operation: DW=14, TRACK with dat_o=1000, assert rstn_i async between edges -> dat_o=0 and state_o=00 immediately. After release the FSM stays in TRACK and output resumes 3 cycles later.
- P only: Kp=4096, Ki=Kd=0, sp=1000, dat_i=0, trig_i=0, thr=750 -> dat_o=1000 on the 3rd edge; Kp=-4096 -> dat_o=-1000.
- Hold entry and output mode:
  - from the P-only setup, trig_i=800 -> state_o=01 next edge;
  - mode[1]=0: dat_o=0 after the pipeline flushes;
  - mode[1]=1: dat_o stays 1000 throughout HOLD/SETTLE.
- Settle timing: set_settle_i=63, trig_i drops to 0 -> SETTLE for exactly 64 cycles, then TRACK; dat_o=1000 again 3 cycles later.
  - Re-trigger at SETTLE cycle 10 -> HOLD, counter restarts at 0.
  - set_settle_i=0 -> SETTLE lasts 1 cycle.
- Integrator saturation: Ki=8191, sp=8191, dat_i=-8192 -> int_reg climbs and clamps at 0x7FFFFFFF, dat_o=0x1FFF.
  - Mirror case -> 0x80000000, dat_o=0x2000.
  - int_rst_i pulse during HOLD -> int_reg=0 next edge.
- Polarity: mode[0]=1, thr=-750, trig_i=-800 -> HOLD; trig_i=-700 -> SETTLE.
  - mode[0]=0 with the same values -> no HOLD at -800.

Source files
------------

// File: rtl/red_pitaya_pid_block_shg.sv
// Sample-and-hold PID controller channel.
// The error is gated by a threshold on a trigger input: TRACK integrates the
// set-point error, HOLD and SETTLE zero it, and a programmable settle
// interval follows every hold. The output is either the live PID value or a
// copy that freezes while the controller is not tracking.
module red_pitaya_pid_block_shg #(
  parameter int DW  = 14,
  parameter int PSR = 12,
  parameter int ISR = 18,
  parameter int DSR = 10,
  parameter int CW  = 8
)(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] dat_i,
  input  logic [DW-1:0] trig_i,
  output logic [DW-1:0] dat_o,
  output logic [1:0]    state_o,
  input  logic [DW-1:0] set_sp_i,
  input  logic [DW-1:0] set_kp_i,
  input  logic [DW-1:0] set_ki_i,
  input  logic [DW-1:0] set_kd_i,
  input  logic [DW-1:0] set_thr_i,
  input  logic [CW-1:0] set_settle_i,
  input  logic [1:0]    set_mode_i,
  input  logic          int_rst_i
);

  // Product width, P/D slice widths, PID sum width, integrator slice width.
  localparam int PW  = 2*DW + 1;
  localparam int KPW = PW - PSR;
  localparam int KDW = PW - DSR;
  localparam int SW  = 33;
  localparam int ISW = 32 - ISR;

  typedef enum logic [1:0] {
    TRACK  = 2'b00,
    HOLD   = 2'b01,
    SETTLE = 2'b10
  } state_t;

  state_t                 state;
  state_t                 state_p0;
  state_t                 state_p1;
  state_t                 state_p2;
  logic   [CW-1:0]        settle_cnt;
  logic                   trig_active;

  logic signed [DW:0]     err_next;
  logic signed [DW:0]     error_p0;

  logic signed [PW-1:0]   err_ext;
  logic signed [PW-1:0]   kp_ext;
  logic signed [PW-1:0]   ki_ext;
  logic signed [PW-1:0]   kd_ext;

  logic signed [KPW-1:0]  kp_reg_p1;
  logic signed [PW-1:0]   ki_mult_p1;
  logic signed [KDW-1:0]  kd_reg_p1;
  logic signed [KDW-1:0]  kd_reg_r_p2;
  logic signed [KDW:0]    kd_reg_s_p2;
  logic signed [31:0]     int_reg_p2;
  logic signed [32:0]     int_sum;
  logic signed [ISW-1:0]  int_shr;
  logic signed [SW-1:0]   pid_sum;
  logic        [DW-1:0]   pid_out_p3;
  logic        [DW-1:0]   hold_out_p4;

  // Clamp the 33-bit integrator sum back into a 32-bit register.
  function automatic logic signed [31:0] sat_int(input logic signed [32:0] s);
    case (s[32:31])
      2'b01:   sat_int = 32'sh7FFF_FFFF;
      2'b10:   sat_int = 32'sh8000_0000;
      default: sat_int = s[31:0];
    endcase
  endfunction

  // Clamp the PID sum to the signed DW-bit output range.
  function automatic logic [DW-1:0] sat_out(input logic signed [SW-1:0] s);
    logic [SW-DW:0] top;
    top = s[SW-1:DW-1];
    if ((top == '0) || (top == '1))
      sat_out = s[DW-1:0];
    else if (s[SW-1])
      sat_out = {1'b1, {(DW-1){1'b0}}};
    else
      sat_out = {1'b0, {(DW-1){1'b1}}};
  endfunction

  assign err_next = $signed({set_sp_i[DW-1], set_sp_i}) - $signed({dat_i[DW-1], dat_i});

  // Operands sign-extended to the full product width so every multiply is exact.
  assign err_ext = {{(PW-DW-1){error_p0[DW]}}, error_p0};
  assign kp_ext  = {{(PW-DW){set_kp_i[DW-1]}}, set_kp_i};
  assign ki_ext  = {{(PW-DW){set_ki_i[DW-1]}}, set_ki_i};
  assign kd_ext  = {{(PW-DW){set_kd_i[DW-1]}}, set_kd_i};

  // Trigger comparison; bit 0 of the mode selects which side of the threshold is active.
  always_comb begin
    trig_active = 1'b0;
    if (set_mode_i[0])
      trig_active = ($signed(trig_i) <= $signed(set_thr_i));
    else
      trig_active = ($signed(trig_i) >= $signed(set_thr_i));
  end

  // ---- stage p0: FSM, settle counter and gated error (uses pre-transition state)
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= TRACK;
      settle_cnt <= '0;
      error_p0   <= '0;
    end else begin
      error_p0 <= (state == TRACK) ? err_next : '0;
      case (state)
        TRACK: begin
          if (trig_active)
            state <= HOLD;
        end
        HOLD: begin
          settle_cnt <= '0;
          if (!trig_active)
            state <= SETTLE;
        end
        SETTLE: begin
          if (trig_active) begin
            state      <= HOLD;
            settle_cnt <= '0;
          end else if (settle_cnt == set_settle_i) begin
            state <= TRACK;
          end else if (settle_cnt != '1) begin
            settle_cnt <= settle_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: state <= TRACK;
      endcase
    end
  end

  // ---- stage p1: scaled P and D products, raw integrator increment
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      kp_reg_p1  <= '0;
      ki_mult_p1 <= '0;
      kd_reg_p1  <= '0;
    end else begin
      kp_reg_p1  <= KPW'((err_ext * kp_ext) >>> PSR);
      ki_mult_p1 <= err_ext * ki_ext;
      kd_reg_p1  <= KDW'((err_ext * kd_ext) >>> DSR);
    end
  end

  assign int_sum = {{(33-PW){ki_mult_p1[PW-1]}}, ki_mult_p1} + {int_reg_p2[31], int_reg_p2};
  assign int_shr = int_reg_p2[31:ISR];

  // ---- stage p2: saturating integrator and derivative difference
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      int_reg_p2  <= '0;
      kd_reg_r_p2 <= '0;
      kd_reg_s_p2 <= '0;
    end else begin
      if (int_rst_i)
        int_reg_p2 <= '0;
      else
        int_reg_p2 <= sat_int(int_sum);
      kd_reg_r_p2 <= kd_reg_p1;
      kd_reg_s_p2 <= $signed({kd_reg_p1[KDW-1], kd_reg_p1}) - $signed({kd_reg_r_p2[KDW-1], kd_reg_r_p2});
    end
  end

  assign pid_sum = {{(SW-KPW){kp_reg_p1[KPW-1]}}, kp_reg_p1}
                 + {{(SW-ISW){int_shr[ISW-1]}}, int_shr}
                 + {{(SW-KDW-1){kd_reg_s_p2[KDW]}}, kd_reg_s_p2};

  // ---- stage p3: saturated PID output
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)
      pid_out_p3 <= '0;
    else
      pid_out_p3 <= sat_out(pid_sum);
  end

  // ---- stage p4: state delayed to output alignment and frozen-output register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_p0    <= TRACK;
      state_p1    <= TRACK;
      state_p2    <= TRACK;
      hold_out_p4 <= '0;
    end else begin
      state_p0 <= state;
      state_p1 <= state_p0;
      state_p2 <= state_p1;
      if (state_p2 == TRACK)
        hold_out_p4 <= pid_out_p3;
    end
  end

  assign dat_o   = set_mode_i[1] ? hold_out_p4 : pid_out_p3;
  assign state_o = state;

endmodule

// File: tb/tb_red_pitaya_pid_block_shg.sv
// Bench for the sample-and-hold PID channel: directed scenarios plus random
// traffic, compared against a cycle-indexed history model of the controller.
module tb_red_pitaya_pid_block_shg;

  logic        clk = 1'b0;
  logic        rstn;
  logic [13:0] dat, trig, sp, kp, ki, kd, thr;
  logic [7:0]  settle;
  logic [1:0]  mode;
  logic        irst;
  logic [13:0] dat_o;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  red_pitaya_pid_block_shg #(.DW(14), .PSR(12), .ISR(18), .DSR(10), .CW(8)) dut (
    .clk_i(clk), .rstn_i(rstn), .dat_i(dat), .trig_i(trig), .dat_o(dat_o),
    .state_o(state_o), .set_sp_i(sp), .set_kp_i(kp), .set_ki_i(ki), .set_kd_i(kd),
    .set_thr_i(thr), .set_settle_i(settle), .set_mode_i(mode), .int_rst_i(irst)
  );

  // Reference model: every quantity is a history indexed by clock edge t
  // (value visible after edge t). 0=TRACK 1=HOLD 2=SETTLE.
  localparam int     N     = 4096;
  localparam longint I_MAX = 2147483647;
  localparam longint I_MIN = -I_MAX - 1;
  longint st_a[N], err_a[N], p_a[N], m_a[N], d_a[N], ds_a[N], i_a[N], pid_a[N], out_a[N];
  int cyc = 8;
  int sstart = 0;
  int mt;
  bit mtrig;

  function automatic longint sx(input logic [13:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc = cyc + 6;
      for (int k = cyc - 5; k <= cyc; k++) begin
        st_a[k] = 0; err_a[k] = 0; p_a[k] = 0; m_a[k] = 0; d_a[k] = 0;
        ds_a[k] = 0; i_a[k] = 0; pid_a[k] = 0; out_a[k] = 0;
      end
    end else begin
      mt = cyc + 1;
      if (mode[0]) mtrig = (sx(trig) <= sx(thr));
      else         mtrig = (sx(trig) >= sx(thr));
      case (st_a[mt-1])
        0: st_a[mt] = mtrig ? 1 : 0;
        1: if (mtrig) st_a[mt] = 1; else begin st_a[mt] = 2; sstart = mt; end
        default: begin
          if (mtrig) st_a[mt] = 1;
          else if ((mt - 1 - sstart) == int'(settle)) st_a[mt] = 0;
          else st_a[mt] = 2;
        end
      endcase
      err_a[mt] = (st_a[mt-1] == 0) ? sx(sp) - sx(dat) : 0;
      p_a[mt]   = (err_a[mt-1] * sx(kp)) >>> 12;
      m_a[mt]   = err_a[mt-1] * sx(ki);
      d_a[mt]   = (err_a[mt-1] * sx(kd)) >>> 10;
      ds_a[mt]  = d_a[mt-1] - d_a[mt-2];
      i_a[mt]   = irst ? 0 : clamp(i_a[mt-1] + m_a[mt-1], I_MIN, I_MAX);
      pid_a[mt] = clamp(p_a[mt-1] + (i_a[mt-1] >>> 18) + ds_a[mt-1], -8192, 8191);
      out_a[mt] = (st_a[mt-4] != 0) ? out_a[mt-1] : pid_a[mt-1];
      cyc = mt;
    end
  end

  function automatic logic [13:0] exp_dat();
    longint v;
    v = mode[1] ? out_a[cyc] : pid_a[cyc];
    return v[13:0];
  endfunction

  function automatic logic [1:0] exp_st();
    longint v;
    v = st_a[cyc];
    return v[1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Counts consecutive SETTLE cycles after the trigger has been released.
  task automatic run_settle(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (state_o != 2'b10) break;
      n++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; dat = '0; trig = '0; sp = '0; kp = '0; ki = '0; kd = '0;
    thr = 14'd750; settle = '0; mode = '0; irst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (dat_o !== 14'd0) begin n_fail++; $display("FAIL reset_dat dat_o=%0d expected=0", $signed(dat_o)); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state state_o=%0d expected=0", state_o); end
  endtask

  task automatic test_p_only();
    sp = 14'd1000; kp = 14'd4096; ki = '0; kd = '0; dat = '0; trig = '0; thr = 14'd750; mode = 2'b00;
    rstn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (dat_o !== ((i == 3) ? 14'd1000 : 14'd0)) begin
        n_fail++; $display("FAIL p_latency edge=%0d dat_o=%0d expected=%0d", i, $signed(dat_o), (i == 3) ? 1000 : 0);
      end
    end
    kp = 14'(-4096);
    repeat (3) tick();
    n_checks++; if (dat_o !== 14'(-1000)) begin n_fail++; $display("FAIL p_negative dat_o=%0d expected=-1000", $signed(dat_o)); end
    for (int i = 0; i < 16; i++) begin
      dat = 14'($urandom);
      tick();
      n_checks++;
      if (dat_o !== exp_dat() || state_o !== exp_st()) begin
        n_fail++; $display("FAIL p_random cyc=%0d dat_o=%0d st=%0d expected dat=%0d st=%0d", cyc, $signed(dat_o), state_o, $signed(exp_dat()), exp_st());
      end
    end
    kp = 14'd4096; dat = '0;
    repeat (4) tick();
    n_checks++; if (dat_o !== 14'd1000) begin n_fail++; $display("FAIL p_restore dat_o=%0d expected=1000", $signed(dat_o)); end
  endtask

  task automatic test_reset_mid();
    #3 rstn = 1'b0;
    #1;
    n_checks++; if (dat_o !== 14'd0) begin n_fail++; $display("FAIL async_reset_dat dat_o=%0d expected=0", $signed(dat_o)); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL async_reset_state state_o=%0d expected=0", state_o); end
    tick(); tick();
    rstn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (state_o !== 2'b00 || dat_o !== exp_dat()) begin
        n_fail++; $display("FAIL post_reset edge=%0d dat_o=%0d st=%0d expected dat=%0d st=0", i, $signed(dat_o), state_o, $signed(exp_dat()));
      end
    end
    n_checks++; if (dat_o !== 14'd1000) begin n_fail++; $display("FAIL post_reset_resume dat_o=%0d expected=1000", $signed(dat_o)); end
  endtask

  task automatic test_hold_mode();
    mode = 2'b00; trig = 14'd800;
    tick();
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL hold_entry state_o=%0d expected=1", state_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (dat_o !== exp_dat() || state_o !== exp_st()) begin
        n_fail++; $display("FAIL hold_legacy cyc=%0d dat_o=%0d st=%0d expected dat=%0d st=%0d", cyc, $signed(dat_o), state_o, $signed(exp_dat()), exp_st());
      end
    end
    n_checks++; if (dat_o !== 14'd0) begin n_fail++; $display("FAIL hold_legacy_zero dat_o=%0d expected=0", $signed(dat_o)); end
    settle = 8'd3; trig = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (dat_o !== exp_dat() || state_o !== exp_st()) begin
        n_fail++; $display("FAIL settle_legacy cyc=%0d dat_o=%0d st=%0d expected dat=%0d st=%0d", cyc, $signed(dat_o), state_o, $signed(exp_dat()), exp_st());
      end
      if (state_o == 2'b00) break;
    end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL settle_exit state_o=%0d expected=0", state_o); end
    repeat (3) tick();
    n_checks++; if (dat_o !== 14'd1000) begin n_fail++; $display("FAIL track_resume dat_o=%0d expected=1000", $signed(dat_o)); end
    mode = 2'b10;
    tick();
    trig = 14'd800;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++; if (dat_o !== 14'd1000) begin n_fail++; $display("FAIL frozen_hold i=%0d dat_o=%0d expected=1000", i, $signed(dat_o)); end
    end
    trig = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_o == 2'b00) break;
      n_checks++; if (dat_o !== 14'd1000) begin n_fail++; $display("FAIL frozen_settle i=%0d dat_o=%0d expected=1000", i, $signed(dat_o)); end
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (dat_o !== exp_dat() || state_o !== exp_st()) begin
        n_fail++; $display("FAIL frozen_exit cyc=%0d dat_o=%0d st=%0d expected dat=%0d st=%0d", cyc, $signed(dat_o), state_o, $signed(exp_dat()), exp_st());
      end
    end
    mode = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_settle();
    int n;
    settle = 8'd63; trig = 14'd800;
    tick();
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL settle_hold state_o=%0d expected=1", state_o); end
    trig = '0;
    run_settle(n);
    n_checks++; if (n != 64) begin n_fail++; $display("FAIL settle_len63 cycles=%0d expected=64", n); end
    n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL settle_to_track state_o=%0d expected=0", state_o); end
    repeat (3) tick();
    n_checks++; if (dat_o !== 14'd1000) begin n_fail++; $display("FAIL settle_resume dat_o=%0d expected=1000", $signed(dat_o)); end
    trig = 14'd800; tick(); trig = '0;
    repeat (10) tick();
    n_checks++; if (state_o !== 2'b10) begin n_fail++; $display("FAIL retrig_in_settle state_o=%0d expected=2", state_o); end
    trig = 14'd800;
    tick();
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL retrig_hold state_o=%0d expected=1", state_o); end
    trig = '0;
    run_settle(n);
    n_checks++; if (n != 64) begin n_fail++; $display("FAIL retrig_restart cycles=%0d expected=64", n); end
    settle = 8'd0; trig = 14'd800; tick(); trig = '0;
    run_settle(n);
    n_checks++; if (n != 1) begin n_fail++; $display("FAIL settle_len0 cycles=%0d expected=1", n); end
    repeat (3) tick();
  endtask

  task automatic test_int_sat();
    kp = '0; ki = 14'd8191; kd = '0; sp = 14'd8191; dat = 14'(-8192); trig = '0; mode = 2'b00;
    for (int i = 0; i < 40; i++) begin
      tick();
      n_checks++;
      if (dat_o !== exp_dat() || state_o !== exp_st()) begin
        n_fail++; $display("FAIL int_up cyc=%0d dat_o=%0d expected=%0d", cyc, $signed(dat_o), $signed(exp_dat()));
      end
    end
    n_checks++; if (dat_o !== 14'h1FFF) begin n_fail++; $display("FAIL int_pos_clamp dat_o=%0h expected=1fff", dat_o); end
    sp = 14'(-8192); dat = 14'd8191;
    for (int i = 0; i < 80; i++) begin
      tick();
      n_checks++;
      if (dat_o !== exp_dat() || state_o !== exp_st()) begin
        n_fail++; $display("FAIL int_down cyc=%0d dat_o=%0d expected=%0d", cyc, $signed(dat_o), $signed(exp_dat()));
      end
    end
    n_checks++; if (dat_o !== 14'h2000) begin n_fail++; $display("FAIL int_neg_clamp dat_o=%0h expected=2000", dat_o); end
    trig = 14'd800;
    repeat (4) tick();
    n_checks++; if (dat_o !== 14'h2000) begin n_fail++; $display("FAIL int_hold dat_o=%0h expected=2000", dat_o); end
    irst = 1'b1; tick(); irst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (dat_o !== exp_dat() || state_o !== exp_st()) begin
        n_fail++; $display("FAIL int_rst_hold cyc=%0d dat_o=%0d expected=%0d", cyc, $signed(dat_o), $signed(exp_dat()));
      end
    end
    n_checks++; if (dat_o !== 14'd0) begin n_fail++; $display("FAIL int_rst_zero dat_o=%0d expected=0", $signed(dat_o)); end
    ki = '0; trig = '0;
    repeat (4) tick();
  endtask

  task automatic test_polarity();
    kp = 14'd4096; sp = 14'd1000; dat = '0; settle = 8'd5;
    mode = 2'b01; thr = 14'(-750); trig = 14'(-800);
    tick();
    n_checks++; if (state_o !== 2'b01) begin n_fail++; $display("FAIL pol_low_hold state_o=%0d expected=1", state_o); end
    trig = 14'(-700);
    tick();
    n_checks++; if (state_o !== 2'b10) begin n_fail++; $display("FAIL pol_low_settle state_o=%0d expected=2", state_o); end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_o == 2'b00) break;
    end
    mode = 2'b00; trig = 14'(-800);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (state_o !== 2'b00) begin n_fail++; $display("FAIL pol_high_track i=%0d state_o=%0d expected=0", i, state_o); end
    end
  endtask

  task automatic test_random();
    thr = '0;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        kp = 14'(int'($urandom_range(0, 8191)) - 4096);
        ki = 14'(int'($urandom_range(0, 511)) - 256);
        kd = 14'(int'($urandom_range(0, 2047)) - 1024);
        sp = 14'($urandom);
      end
      if (i % 20 == 0) begin
        mode = 2'($urandom);
        settle = 8'($urandom_range(0, 7));
      end
      dat  = 14'($urandom);
      trig = 14'(int'($urandom_range(0, 40)) - 20);
      irst = ($urandom_range(0, 15) == 0);
      if (i == 200) begin
        #1 rstn = 1'b0;
        #1;
        n_checks++;
        if (dat_o !== 14'd0 || state_o !== 2'b00) begin
          n_fail++; $display("FAIL rand_async_reset dat_o=%0d st=%0d expected dat=0 st=0", $signed(dat_o), state_o);
        end
        #1 rstn = 1'b1;
      end
      tick();
      n_checks++;
      if (dat_o !== exp_dat() || state_o !== exp_st()) begin
        n_fail++; $display("FAIL random cyc=%0d dat_o=%0d st=%0d expected dat=%0d st=%0d", cyc, $signed(dat_o), state_o, $signed(exp_dat()), exp_st());
      end
    end
    irst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_reset_mid();
    test_hold_mode();
    test_settle();
    test_int_sat();
    test_polarity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
